// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key codes, one-hot column/row lines and emulator state encoding.
// Used by both the keypad scanner and the keypad emulator.
package keypad_pkg;

    localparam logic [2:0] KEY_100    = 3'b001;
    localparam logic [2:0] KEY_500    = 3'b010;
    localparam logic [2:0] KEY_CANDY  = 3'b101;
    localparam logic [2:0] KEY_CHANGE = 3'b110;
    localparam logic [2:0] KEY_CANCEL = 3'b111;

    localparam logic [2:0] COL_0 = 3'b001;
    localparam logic [2:0] COL_1 = 3'b010;
    localparam logic [2:0] COL_2 = 3'b100;

    localparam logic [3:0] ROW_0 = 4'b0001;
    localparam logic [3:0] ROW_1 = 4'b0010;
    localparam logic [3:0] ROW_2 = 4'b0100;
    localparam logic [3:0] ROW_3 = 4'b1000;

    typedef logic [2:0] state_t;

    localparam state_t StIdle      = 3'd0;
    localparam state_t StBounceIn  = 3'd1;
    localparam state_t StPress     = 3'd2;
    localparam state_t StBounceOut = 3'd3;
    localparam state_t StGap       = 3'd4;

    typedef struct packed {
        logic       valid;
        logic [2:0] col;
        logic [3:0] row;
    } key_map_t;

    function automatic key_map_t decode_key(input logic [2:0] code);
        key_map_t m;
        m = '{valid: 1'b1, col: 3'b000, row: 4'b0000};
        case (code)
            KEY_100:    begin m.col = COL_0; m.row = ROW_0; end
            KEY_500:    begin m.col = COL_1; m.row = ROW_1; end
            KEY_CANDY:  begin m.col = COL_0; m.row = ROW_3; end
            KEY_CHANGE: begin m.col = COL_2; m.row = ROW_3; end
            KEY_CANCEL: begin m.col = COL_1; m.row = ROW_3; end
            default:    m.valid = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// Scanner-to-emulator bundle: column drive, row return and the key request handshake.
interface keypad_emulator_if;

    logic [2:0] col;
    logic [3:0] row;
    logic       key_req;
    logic [2:0] key_code;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output col, key_req, key_code,
        input  row, busy, done, err
    );

    modport slave (
        input  col, key_req, key_code,
        output row, busy, done, err
    );

endinterface

// File: rtl/bounce_lfsr.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, reloads SEED on reset and steps while en is high.
module bounce_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output logic [7:0] lfsr
);

    logic [7:0] lfsr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= SEED;
        end else if (en) begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/keypad_emulator.sv
// Keypad emulator: closes one matrix key per request for the column-scanning keypad reader.
// Define KEYPAD_BOUNCE_EN to add LFSR-driven bounce windows before and after the solid press.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int unsigned PRESS_CYCLES  = 64,
    parameter int unsigned GAP_CYCLES    = 16,
    parameter int unsigned BOUNCE_CYCLES = 8,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input logic              clk,
    input logic              reset,
    keypad_emulator_if.slave kp
);

    if (PRESS_CYCLES < 1 || PRESS_CYCLES > 65535) begin : g_bad_press
        $error("PRESS_CYCLES must be in 1..65535");
    end
    if (GAP_CYCLES < 1 || GAP_CYCLES > 65535) begin : g_bad_gap
        $error("GAP_CYCLES must be in 1..65535");
    end
    if (BOUNCE_CYCLES < 1 || BOUNCE_CYCLES > 255) begin : g_bad_bounce
        $error("BOUNCE_CYCLES must be in 1..255");
    end
    if (LFSR_SEED == 8'h00) begin : g_bad_seed
        $error("LFSR_SEED must be nonzero");
    end

    localparam logic [15:0] PressLast = 16'(PRESS_CYCLES - 1);
    localparam logic [15:0] GapLast   = 16'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  tcol_q, tcol_d;
    logic [3:0]  trow_q, trow_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        closed;
    key_map_t    map;

    assign map = decode_key(kp.key_code);

`ifdef KEYPAD_BOUNCE_EN
    localparam logic [15:0] BounceLast = 16'(BOUNCE_CYCLES - 1);
    localparam state_t      AfterIdle  = StBounceIn;
    localparam state_t      AfterPress = StBounceOut;

    logic [7:0] lfsr;

    bounce_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .lfsr  (lfsr)
    );

    // During bounce windows the contact follows the pseudo-random bit.
    assign closed = (state_q == StPress) ||
                    (((state_q == StBounceIn) || (state_q == StBounceOut)) && lfsr[0]);
`else
    localparam state_t AfterIdle  = StPress;
    localparam state_t AfterPress = StGap;

    assign closed = (state_q == StPress);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        tcol_d  = tcol_q;
        trow_d  = trow_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (kp.key_req) begin
                    if (map.valid) begin
                        tcol_d  = map.col;
                        trow_d  = map.row;
                        state_d = AfterIdle;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StPress: begin
                if (cnt_q == PressLast) begin
                    state_d = AfterPress;
                    cnt_d   = '0;
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
`ifdef KEYPAD_BOUNCE_EN
            StBounceIn: begin
                if (cnt_q == BounceLast) begin
                    state_d = StPress;
                    cnt_d   = '0;
                end
            end
            StBounceOut: begin
                if (cnt_q == BounceLast) begin
                    state_d = StGap;
                    cnt_d   = '0;
                end
            end
`endif
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            tcol_q  <= '0;
            trow_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tcol_q  <= tcol_d;
            trow_q  <= trow_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // tcol_q is one-hot or zero, so an exact match also rejects idle and non-one-hot columns.
    assign kp.row  = (closed && (kp.col == tcol_q)) ? trow_q : 4'b0000;
    assign kp.busy = (state_q != StIdle);
    assign kp.done = done_q;
    assign kp.err  = err_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Scoreboard bench for keypad_emulator: stimulus queues expected row/busy samples and
// done/err pulses, a negedge monitor pops and compares them against the DUT.
`timescale 1ns/1ps
module tb_keypad_emulator;

    localparam int unsigned P       = 4;
    localparam int unsigned G       = 2;
    localparam int unsigned B_PARAM = 8;
`ifdef KEYPAD_BOUNCE_EN
    localparam int unsigned B = B_PARAM;
`else
    localparam int unsigned B = 0;
`endif
    // Cycle offset, from the request cycle, of the done pulse.
    localparam int unsigned N    = 2 * B + P + G + 1;
    localparam logic [7:0]  SEED = 8'hA5;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  row;
        logic        busy;
    } snap_t;

    typedef struct {
        int unsigned cyc;
        logic [1:0]  kind;  // {done, err}
    } pulse_t;

    logic        clk;
    logic        reset;
    int unsigned cyc       = 0;
    int unsigned lfsr_base = 0;
    int          n_cmp     = 0;
    int          n_bad     = 0;
    snap_t       sq[$];
    pulse_t      pq[$];
    snap_t       mon_s;
    pulse_t      mon_p;

    keypad_emulator_if kp ();

    keypad_emulator #(
        .PRESS_CYCLES  (P),
        .GAP_CYCLES    (G),
        .BOUNCE_CYCLES (B_PARAM),
        .LFSR_SEED     (SEED)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] lfsr_at(input int unsigned c);
        logic [7:0] q;
        q = SEED;
        for (int unsigned i = lfsr_base; i < c; i++) q = {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        return q;
    endfunction

    function automatic logic [3:0] exp_row(input int unsigned k, input int unsigned c,
                                           input logic [2:0] tcol, input logic [3:0] trow,
                                           input logic [2:0] col);
        logic [7:0] l;
        logic       closed;
        l = lfsr_at(c);
        if (k >= B + 1 && k <= B + P) closed = 1'b1;
        else if ((k >= 1 && k <= B) || (k >= B + P + 1 && k <= 2 * B + P)) closed = l[0];
        else closed = 1'b0;
        return (closed && col == tcol) ? trow : 4'b0000;
    endfunction

    function automatic logic [2:0] col_of(input logic [8:0] cols, input int unsigned i);
        return cols[3 * (i % 3) +: 3];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request now; optionally present a second request two cycles later.
    // Returns in the done cycle with key_req low.
    task automatic run_key(input logic [2:0] code, input logic [8:0] cols,
                           input logic [2:0] tcol, input logic [3:0] trow,
                           input logic [2:0] ign_code, input bit ign);
        int unsigned t0;
        t0 = cyc;
        for (int unsigned i = 0; i < N; i++)
            sq.push_back(snap_t'{t0 + i, exp_row(i, t0 + i, tcol, trow, col_of(cols, i)), i != 0});
        pq.push_back(pulse_t'{t0 + N, 2'b10});
        kp.key_req  = 1'b1;
        kp.key_code = code;
        kp.col      = col_of(cols, 0);
        for (int unsigned i = 1; i <= N; i++) begin
            tick();
            kp.key_req  = ign && (i == 2);
            kp.key_code = (ign && i == 2) ? ign_code : code;
            kp.col      = col_of(cols, i);
        end
        kp.key_req = 1'b0;
    endtask

    task automatic expect_idle(input int unsigned n, input logic [2:0] col);
        for (int unsigned i = 0; i < n; i++) begin
            kp.col = col;
            sq.push_back(snap_t'{cyc, 4'b0000, 1'b0});
            tick();
        end
    endtask

    task automatic bad_key(input logic [2:0] code);
        kp.col      = 3'b001;
        kp.key_req  = 1'b1;
        kp.key_code = code;
        sq.push_back(snap_t'{cyc, 4'b0000, 1'b0});
        pq.push_back(pulse_t'{cyc + 1, 2'b01});
        tick();
        kp.key_req = 1'b0;
        sq.push_back(snap_t'{cyc, 4'b0000, 1'b0});
        tick();
    endtask

    always @(negedge clk) begin
        while (pq.size() > 0 && pq[0].cyc < cyc) begin
            mon_p = pq.pop_front();
            check("pulse_missing", 32'(cyc), 32'(mon_p.cyc));
        end
        if (kp.done === 1'b1 || kp.err === 1'b1) begin
            if (pq.size() == 0) begin
                check("pulse_unexpected", 32'({kp.done, kp.err}), 32'd0);
            end else begin
                mon_p = pq.pop_front();
                check("pulse_cycle", 32'(cyc), 32'(mon_p.cyc));
                check("pulse_kind", 32'({kp.done, kp.err}), 32'(mon_p.kind));
            end
        end
        while (sq.size() > 0 && sq[0].cyc <= cyc) begin
            mon_s = sq.pop_front();
            check("row", 32'(kp.row), 32'(mon_s.row));
            check("busy", 32'(kp.busy), 32'(mon_s.busy));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1);
    end

    initial begin
        reset       = 1'b0;
        kp.col      = 3'b001;
        kp.key_req  = 1'b1;
        kp.key_code = 3'b001;
        repeat (2) @(posedge clk);
        #1;
        check("reset_row", 32'(kp.row), 32'd0);
        check("reset_busy", 32'(kp.busy), 32'd0);
        check("reset_done", 32'(kp.done), 32'd0);
        check("reset_err", 32'(kp.err), 32'd0);
        kp.key_req = 1'b0;
        reset      = 1'b1;
        lfsr_base  = cyc;

        // First request right after release, column cycling 001/010/100.
        run_key(3'b001, {3'b100, 3'b010, 3'b001}, 3'b001, 4'b0001, 3'b000, 1'b0);
        expect_idle(2, 3'b001);
        // Change key: held on its column, then off its column (issued in the done cycle).
        run_key(3'b110, {3'b100, 3'b100, 3'b100}, 3'b100, 4'b1000, 3'b000, 1'b0);
        run_key(3'b110, {3'b001, 3'b001, 3'b001}, 3'b100, 4'b1000, 3'b000, 1'b0);
        expect_idle(1, 3'b001);
        bad_key(3'b011);
        bad_key(3'b000);
        bad_key(3'b100);
        // Ignored second request while busy, then a request in the done cycle.
        run_key(3'b001, {3'b001, 3'b001, 3'b001}, 3'b001, 4'b0001, 3'b010, 1'b1);
        run_key(3'b010, {3'b010, 3'b011, 3'b001}, 3'b010, 4'b0010, 3'b000, 1'b0);
        run_key(3'b101, {3'b001, 3'b001, 3'b001}, 3'b001, 4'b1000, 3'b011, 1'b1);
        run_key(3'b111, {3'b110, 3'b010, 3'b000}, 3'b010, 4'b1000, 3'b000, 1'b0);
        expect_idle(1, 3'b001);

        // Reset in the second PRESS cycle.
        kp.col      = 3'b001;
        kp.key_code = 3'b001;
        kp.key_req  = 1'b1;
        sq.push_back(snap_t'{cyc, 4'b0000, 1'b0});
        begin
            int unsigned t0;
            t0 = cyc;
            tick();
            kp.key_req = 1'b0;
            for (int unsigned i = 1; i <= B + 1; i++) begin
                sq.push_back(snap_t'{cyc, exp_row(i, cyc, 3'b001, 4'b0001, 3'b001), 1'b1});
                tick();
            end
            check("row_before_reset", 32'(kp.row), 32'(exp_row(cyc - t0, cyc, 3'b001, 4'b0001,
                                                                3'b001)));
        end
        reset = 1'b0;
        #1;
        check("midreset_row", 32'(kp.row), 32'd0);
        check("midreset_busy", 32'(kp.busy), 32'd0);
        check("midreset_done", 32'(kp.done), 32'd0);
        check("midreset_err", 32'(kp.err), 32'd0);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        lfsr_base = cyc;
`ifdef KEYPAD_BOUNCE_EN
        check("lfsr_after_reset", 32'(dut.u_lfsr.lfsr_q), 32'(SEED));
`endif
        run_key(3'b010, {3'b010, 3'b010, 3'b010}, 3'b010, 4'b0010, 3'b000, 1'b0);
        expect_idle(3, 3'b010);

        check("pulse_queue_drained", 32'(pq.size()), 32'd0);
        check("sample_queue_drained", 32'(sq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
